matmul_result_display: RTL and testbench
========================================

# matmul_result_display

Downstream stage of the 2x2 matrix multiplier tile. Accepts one completed result matrix, four 4-bit unsigned elements plus an error flag, through a valid/ready handshake. It then steps through the elements on a single seven-segment digit, holding each one for a programmable number of cycles. Operand-range errors show as "E" instead of the elements.

## Interface
Parameters:
- DWELL_CYCLES, default 1000: cycles (with ena high) each element is displayed; legal range 1..2^20.
- ELEM_W, default 4: width of one result element; fixed at 4 for this tile.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  tile enable; when low, all state, counters and registered outputs freeze.
- res_valid  in  1  a result matrix is presented.
- res_ready  out  1  combinational: ena & (state==IDLE).
- res_data  in  16  {c22[15:12], c21[11:8], c12[7:4], c11[3:0]}, unsigned.
- res_err  in  1  operand-range error for this result; qualified by res_valid.
- seg  out  7  registered segment drive {g,f,e,d,c,b,a}, active-high.
- dp  out  1  registered decimal point; marks element c11 (start of sequence).
- elem_idx  out  2  registered index of the displayed element: 0=c11, 1=c12, 2=c21, 3=c22.
- busy  out  1  registered; high in SHOW and ERR.
- done  out  1  registered one-cycle pulse when a sequence completes.

## Operation
- States: IDLE, SHOW, ERR.
- IDLE:
  - seg=0 (blank), dp=0, elem_idx=0, busy=0.
  - Accept on res_valid & res_ready at a clock edge: latch res_data into the hold register, load dwell counter with DWELL_CYCLES-1.
  - Go to SHOW (res_err=0) or ERR (res_err=1).
- SHOW:
  - seg = hex decode of element[elem_idx]; codes 0..F are 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - dp = (elem_idx==0).
  - Each ena cycle the counter decrements. At 0 with elem_idx<3: elem_idx+1, reload counter.
  - At 0 with elem_idx==3: go to IDLE, done=1 for one cycle.
- ERR:
  - seg=79 ("E"), dp=1, elem_idx=0 for DWELL_CYCLES cycles.
  - Then go to IDLE with a done pulse.
- The hold register is written only on accept, so the upstream block may change res_data freely after the handshake.
- Result values from the multiplier lie in 0..8; the full hex range is still decoded.
- Reset (at any time, including mid-sequence):
  - State returns to IDLE immediately.
  - seg=0, dp=0, elem_idx=0, busy=0, done=0; counter and hold register are cleared.
  - res_ready follows ena.

## Timing
- Accept edge k: from edge k, seg shows c11 with dp=1 and busy=1.
- Each element is visible for exactly DWELL_CYCLES ena-high cycles.
- done is high for the single cycle starting at edge k + 4*DWELL_CYCLES (SHOW) or k + DWELL_CYCLES (ERR). That cycle is already IDLE.
- Back-to-back operation: res_ready is high in the done cycle, so a new accept there starts the next sequence on the following edge with no blank gap.
- ena low: no transitions, counter holds, done holds its value; the pulse width counts ena-high cycles only.
- res_valid while not ready is ignored, and the data is not latched.
- DWELL_CYCLES=1: elements advance every cycle.

## Structure
- Shared package matmul_pkg:
  - display state enum (IDLE/SHOW/ERR);
  - SEG_BLANK=7'h00 and SEG_E=7'h79;
  - the 16-entry segment code constant;
  - RES_W=16.
- Dwell counter width is $clog2(DWELL_CYCLES), minimum 1.
- Sub-module hex_to_seg7: combinational, 4-bit in, 7-bit out, used by this block and reusable by other tiles.

## Test plan
- Reset values: rst_n low with ena=1 -> seg=00, dp=0, busy=0, done=0, res_ready=1. Assert rst_n low during SHOW elem_idx=2 -> same values next cycle.
- Normal sequence, DWELL_CYCLES=3: accept res_data=16'h8421 -> seg 06,5B,66,7F for 3 cycles each; dp high only on the first; done pulse at cycle 12 after accept.
- Error: accept with res_err=1 -> seg=79, dp=1 for 3 cycles, done pulse, no element shown.
- Handshake: res_valid held high during SHOW -> res_ready=0, no relatch; res_data changed mid-sequence -> displayed values unchanged. Accept in the done cycle -> next sequence starts with no gap.
- ena low for 5 cycles mid-element -> that element remains displayed for 3+5 cycles total, with no skipped or duplicated elements.
- Hex coverage: res_data=16'hFEDC -> seg 39,5E,79,71.

Source files
------------

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared types and constants for the 2x2 matmul result display.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int RES_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        ERR  = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_E     = 7'h79;

    // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_HEX_CODES [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg7
// Description : Combinational hex digit to seven-segment pattern decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import matmul_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_HEX_CODES[i_hex];
    end

endmodule
`default_nettype wire

// File: rtl/matmul_result_display.sv
`default_nettype none
// ============================================================================
// Module      : matmul_result_display
// Description : Latches one 2x2 result matrix and steps its elements across a
//               single seven-segment digit, or shows "E" on an operand error.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_result_display
    import matmul_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int ELEM_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [RES_W-1:0] res_data,
    input  logic             res_err,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [1:0]       elem_idx,
    output logic             busy,
    output logic             done
);

    localparam int              CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    disp_state_t                 r_state;
    disp_state_t                 w_state_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic [3:0][ELEM_W-1:0]      r_hold;
    logic [3:0][ELEM_W-1:0]      w_hold_nxt;
    logic [1:0]                  w_idx_nxt;
    logic                        w_done_nxt;
    logic [6:0]                  w_seg_nxt;
    logic                        w_dp_nxt;
    logic                        w_busy_nxt;
    logic [ELEM_W-1:0]           w_elem_nxt;
    logic [6:0]                  w_elem_seg;
    logic                        w_accept;

    assign res_ready = ena && (r_state == IDLE);
    assign w_accept  = res_valid && res_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_idx_nxt   = elem_idx;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_idx_nxt = 2'd0;
                if (w_accept) begin
                    w_hold_nxt  = res_data;
                    w_cnt_nxt   = C_RELOAD;
                    w_state_nxt = res_err ? ERR : SHOW;
                end
            end
            SHOW: begin
                if (r_cnt == '0) begin
                    if (elem_idx != 2'd3) begin
                        w_idx_nxt = elem_idx + 2'd1;
                        w_cnt_nxt = C_RELOAD;
                    end else begin
                        w_idx_nxt   = 2'd0;
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ERR: begin
                w_idx_nxt = 2'd0;
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    assign w_elem_nxt = w_hold_nxt[w_idx_nxt];

    hex_to_seg7 u_hex_to_seg7 (
        .i_hex (w_elem_nxt),
        .o_seg (w_elem_seg)
    );

    always_comb begin
        w_seg_nxt  = SEG_BLANK;
        w_dp_nxt   = 1'b0;
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            SHOW: begin
                w_seg_nxt  = w_elem_seg;
                w_dp_nxt   = (w_idx_nxt == 2'd0);
                w_busy_nxt = 1'b1;
            end
            ERR: begin
                w_seg_nxt  = SEG_E;
                w_dp_nxt   = 1'b1;
                w_busy_nxt = 1'b1;
            end
            default: begin
                w_seg_nxt  = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hold   <= '0;
            elem_idx <= 2'd0;
            seg      <= SEG_BLANK;
            dp       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (ena) begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hold   <= w_hold_nxt;
            elem_idx <= w_idx_nxt;
            seg      <= w_seg_nxt;
            dp       <= w_dp_nxt;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul_result_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_result_display
// Description : Directed self-checking bench for matmul_result_display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_result_display;

    localparam int DWELL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [15:0] res_data = 16'h0000;
    logic        res_err = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  elem_idx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    matmul_result_display #(
        .DWELL_CYCLES (DWELL),
        .ELEM_W       (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .seg       (seg),
        .dp        (dp),
        .elem_idx  (elem_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_seg"},  16'(seg),  16'h00);
        check({tag, "_dp"},   16'(dp),   16'h0);
        check({tag, "_idx"},  16'(elem_idx), 16'h0);
        check({tag, "_busy"}, 16'(busy), 16'h0);
    endtask

    // Walks 4 elements x DWELL cycles and ends on the done cycle.
    task automatic check_show(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input bit corrupt);
        logic [6:0] exp_seg [4];
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        for (int e = 0; e < 4; e++) begin
            for (int c = 0; c < DWELL; c++) begin
                string t;
                t = $sformatf("%s_e%0d_c%0d", tag, e, c);
                check({t, "_seg"}, 16'(seg), 16'(exp_seg[e]));
                check({t, "_dp"},  16'(dp),  16'(e == 0));
                check({t, "_idx"}, 16'(elem_idx), 16'(e));
                check({t, "_busy"}, 16'(busy), 16'h1);
                if (c == 0) begin
                    check({t, "_ready"}, 16'(res_ready), 16'h0);
                    check({t, "_done"},  16'(done), 16'h0);
                end
                if (corrupt && e == 1 && c == 0) begin
                    res_data = 16'h1111;
                    res_err  = 1'b1;
                end
                step();
            end
        end
        check({tag, "_done_pulse"}, 16'(done), 16'h1);
        check({tag, "_done_ready"}, 16'(res_ready), 16'h1);
        check_idle_outputs({tag, "_done_cyc"});
    endtask

    initial begin
        // Reset values
        #1;
        check_idle_outputs("rst");
        check("rst_done",  16'(done), 16'h0);
        check("rst_ready", 16'(res_ready), 16'h1);
        step();
        rst_n = 1'b1;
        step();
        check_idle_outputs("post_rst");

        // Normal sequence
        res_valid = 1'b1; res_data = 16'h8421; res_err = 1'b0;
        check("acc_ready", 16'(res_ready), 16'h1);
        step();
        res_valid = 1'b0;
        check_show("norm", 7'h06, 7'h5B, 7'h66, 7'h7F, 1'b0);
        step();
        check("norm_done_clr", 16'(done), 16'h0);

        // Error path
        res_valid = 1'b1; res_data = 16'h8421; res_err = 1'b1;
        step();
        res_valid = 1'b0; res_err = 1'b0;
        for (int c = 0; c < DWELL; c++) begin
            check($sformatf("err_c%0d_seg", c),  16'(seg), 16'h79);
            check($sformatf("err_c%0d_dp", c),   16'(dp), 16'h1);
            check($sformatf("err_c%0d_idx", c),  16'(elem_idx), 16'h0);
            check($sformatf("err_c%0d_busy", c), 16'(busy), 16'h1);
            check($sformatf("err_c%0d_done", c), 16'(done), 16'h0);
            step();
        end
        check("err_done", 16'(done), 16'h1);
        check_idle_outputs("err_done_cyc");
        step();
        check("err_done_clr", 16'(done), 16'h0);

        // Valid held through SHOW with changing data, then back-to-back accept
        res_valid = 1'b1; res_data = 16'h0765; res_err = 1'b0;
        step();
        check_show("hs", 7'h6D, 7'h7D, 7'h07, 7'h3F, 1'b1);
        res_data = 16'hFEDC; res_err = 1'b0;
        step();
        res_valid = 1'b0;
        check_show("hex", 7'h39, 7'h5E, 7'h79, 7'h71, 1'b0);
        step();

        // ena low for 5 cycles during the second element
        res_valid = 1'b1; res_data = 16'h8421;
        step();
        res_valid = 1'b0;
        for (int t = 0; t < 17; t++) begin
            logic [6:0] es;
            if (t < 3)       es = 7'h06;
            else if (t < 11) es = 7'h5B;
            else if (t < 14) es = 7'h66;
            else             es = 7'h7F;
            check($sformatf("ena_t%0d_seg", t),  16'(seg), 16'(es));
            check($sformatf("ena_t%0d_done", t), 16'(done), 16'h0);
            ena = (t >= 4 && t <= 8) ? 1'b0 : 1'b1;
            step();
        end
        check("ena_done", 16'(done), 16'h1);
        check("ena_done_seg", 16'(seg), 16'h00);
        ena = 1'b0;
        #1;
        check("ena_low_ready", 16'(res_ready), 16'h0);
        step();
        check("ena_done_hold", 16'(done), 16'h1);
        ena = 1'b1;
        step();
        check("ena_done_clr", 16'(done), 16'h0);

        // Reset mid-sequence at elem_idx 2
        res_valid = 1'b1; res_data = 16'h8421;
        step();
        res_valid = 1'b0;
        for (int i = 0; i < 2 * DWELL; i++) step();
        check("mid_idx", 16'(elem_idx), 16'h2);
        check("mid_seg", 16'(seg), 16'h66);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        check("mid_rst_done",  16'(done), 16'h0);
        check("mid_rst_ready", 16'(res_ready), 16'h1);
        step();
        rst_n = 1'b1;
        step();
        check_idle_outputs("mid_rst_rel");
        check("mid_rst_rel_done", 16'(done), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
